// File: rtl/gpp_host_loader_pkg.sv
// Shared widths and FSM encodings for the GPP host loader.
// SA_WIDTH / D_WIDTH fall back to local defaults when no define.h has been read.
`ifndef SA_WIDTH
`define SA_WIDTH 10
`endif
`ifndef D_WIDTH
`define D_WIDTH 16
`endif

package gpp_host_loader_pkg;

  localparam int HL_ADDR_W = `SA_WIDTH;
  localparam int HL_DATA_W = `D_WIDTH;
  localparam int HL_SKID_DEPTH = 2;

  typedef enum logic [2:0] {
    HL_IDLE = 3'd0,
    HL_LOAD = 3'd1,
    HL_RUN  = 3'd2,
    HL_DUMP = 3'd3,
    HL_FIN  = 3'd4
  } hl_state_t;

endpackage

// File: rtl/gpp_host_loader_skid_buf.sv
// hl_skid_buf: two-entry in-order FIFO that holds SRAM read data until the
// dump stream accepts it. Head word and valid flag are both registered.
module hl_skid_buf
  import gpp_host_loader_pkg::*;
#(
  parameter int DATA_W = HL_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              valid,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] tail;

  // The producer never pushes into a full buffer, so no overflow handling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
      valid <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= push_data;
          else tail <= push_data;
          count <= count + 2'd1;
          valid <= 1'b1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
          valid <= (count == 2'(HL_SKID_DEPTH));
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/gpp_host_loader.sv
// Host-side port-B controller for the GPP SRAM: load image, run core, dump window.
// Optional checksum outputs are enabled with `define GPP_HOST_LOADER_CHECKSUM_EN.
module gpp_host_loader
  import gpp_host_loader_pkg::*;
#(
  parameter int ADDR_W = HL_ADDR_W,
  parameter int DATA_W = HL_DATA_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [ADDR_W-1:0] dump_base,
  input  logic [ADDR_W:0]   dump_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] Addr2,
  output logic [DATA_W-1:0] Data_I,
  output logic              en2,
  output logic              we2,
  input  logic [DATA_W-1:0] Data2_O,
  input  logic              Done,
  output logic              core_rst,
  output logic              busy,
  output logic              finished
`ifdef GPP_HOST_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] load_sum,
  output logic [DATA_W-1:0] dump_sum
`endif
);

  hl_state_t         state;
  logic [ADDR_W:0]   load_len_q;
  logic [ADDR_W:0]   dump_len_q;
  logic [ADDR_W-1:0] dump_base_q;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   acc_cnt;
  logic              first_run;
  logic              rd_valid;
  logic [1:0]        skid_count;
  logic              skid_pop;
  logic              in_hs;
  logic [2:0]        pending;

  assign in_hs    = in_valid & in_ready;
  assign skid_pop = out_valid & out_ready;
  // Buffered words plus reads still on their way back from the SRAM.
  assign pending  = {1'b0, skid_count} + {2'b00, en2 & ~we2} + {2'b00, rd_valid};

  hl_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .clk      (Clk),
    .rst_n    (Rst),
    .push     (rd_valid),
    .push_data(Data2_O),
    .pop      (skid_pop),
    .head     (out_data),
    .valid    (out_valid),
    .count    (skid_count)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state       <= HL_IDLE;
      load_len_q  <= '0;
      dump_len_q  <= '0;
      dump_base_q <= '0;
      cnt         <= '0;
      acc_cnt     <= '0;
      first_run   <= 1'b0;
      rd_valid    <= 1'b0;
      Addr2       <= '0;
      Data_I      <= '0;
      en2         <= 1'b0;
      we2         <= 1'b0;
      core_rst    <= 1'b1;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      finished    <= 1'b0;
    end else begin
      en2      <= 1'b0;
      we2      <= 1'b0;
      finished <= 1'b0;
      rd_valid <= en2 & ~we2;
      case (state)
        HL_IDLE: begin
          if (start) begin
            load_len_q  <= load_len;
            dump_len_q  <= dump_len;
            dump_base_q <= dump_base;
            cnt         <= '0;
            acc_cnt     <= '0;
            busy        <= 1'b1;
            if (load_len != '0) begin
              state    <= HL_LOAD;
              in_ready <= 1'b1;
            end else begin
              state     <= HL_RUN;
              core_rst  <= 1'b0;
              first_run <= 1'b1;
            end
          end
        end
        // The core leaves reset only once the final write has reached the SRAM.
        HL_LOAD: begin
          if (in_ready) begin
            if (in_valid) begin
              en2    <= 1'b1;
              we2    <= 1'b1;
              Addr2  <= cnt[ADDR_W-1:0];
              Data_I <= in_data;
              cnt    <= cnt + 1'b1;
              if (cnt + 1'b1 == load_len_q) in_ready <= 1'b0;
            end
          end else begin
            state     <= HL_RUN;
            core_rst  <= 1'b0;
            first_run <= 1'b1;
          end
        end
        HL_RUN: begin
          if (first_run) begin
            first_run <= 1'b0;
          end else if (Done) begin
            core_rst <= 1'b1;
            cnt      <= '0;
            acc_cnt  <= '0;
            if (dump_len_q == '0) begin
              state    <= HL_FIN;
              finished <= 1'b1;
            end else begin
              state <= HL_DUMP;
            end
          end
        end
        HL_DUMP: begin
          if (cnt != dump_len_q && pending < 3'd2) begin
            en2   <= 1'b1;
            Addr2 <= dump_base_q + cnt[ADDR_W-1:0];
            cnt   <= cnt + 1'b1;
          end
          if (skid_pop) begin
            acc_cnt <= acc_cnt + 1'b1;
            if (acc_cnt + 1'b1 == dump_len_q) begin
              state    <= HL_FIN;
              finished <= 1'b1;
            end
          end
        end
        HL_FIN: begin
          state <= HL_IDLE;
          busy  <= 1'b0;
        end
        default: state <= HL_IDLE;
      endcase
    end
  end

`ifdef GPP_HOST_LOADER_CHECKSUM_EN
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      load_sum <= '0;
      dump_sum <= '0;
    end else if (state == HL_IDLE && start) begin
      load_sum <= '0;
      dump_sum <= '0;
    end else begin
      if (in_hs) load_sum <= load_sum + in_data;
      if (skid_pop) dump_sum <= dump_sum + out_data;
    end
  end
`endif

endmodule

// File: tb/tb_gpp_host_loader.sv
// Randomized self-checking bench for gpp_host_loader with an SRAM and image model.
// Checksum outputs are checked when GPP_HOST_LOADER_CHECKSUM_EN is defined.
module tb_gpp_host_loader;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int DEPTH = 1 << AW;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          start;
  logic [AW:0]   load_len;
  logic [AW-1:0] dump_base;
  logic [AW:0]   dump_len;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] Addr2;
  logic [DW-1:0] Data_I;
  logic          en2;
  logic          we2;
  logic [DW-1:0] Data2_O;
  logic          Done;
  logic          core_rst;
  logic          busy;
  logic          finished;
`ifdef GPP_HOST_LOADER_CHECKSUM_EN
  logic [DW-1:0] load_sum;
  logic [DW-1:0] dump_sum;
`endif

  gpp_host_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .load_len(load_len),
    .dump_base(dump_base), .dump_len(dump_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .Addr2(Addr2), .Data_I(Data_I), .en2(en2), .we2(we2),
    .Data2_O(Data2_O), .Done(Done), .core_rst(core_rst),
    .busy(busy), .finished(finished)
`ifdef GPP_HOST_LOADER_CHECKSUM_EN
    , .load_sum(load_sum), .dump_sum(dump_sum)
`endif
  );

  always #5 Clk = ~Clk;

  int testCount = 0;
  int failCount = 0;
  int cyc = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // SRAM port B; never-written words read back as a fixed address hash.
  function automatic logic [DW-1:0] initPattern(input int a);
    return DW'((a * 40503) ^ 23130);
  endfunction

  logic [DW-1:0] mem[DEPTH];
  bit            memValid[DEPTH];

  always @(posedge Clk) begin
    if (en2) begin
      if (we2) begin
        mem[Addr2]      <= Data_I;
        memValid[Addr2] <= 1'b1;
      end else begin
        Data2_O <= memValid[Addr2] ? mem[Addr2] : initPattern(int'(Addr2));
      end
    end
  end

  // Reference image: what the SRAM should hold after each completed load.
  logic [DW-1:0] refData[DEPTH];
  bit            refValid[DEPTH];
  logic [DW-1:0] loadWords[$];

  function automatic logic [DW-1:0] refRead(input int a);
    return refValid[a] ? refData[a] : initPattern(a);
  endfunction

  // Port-B activity log and outstanding-read watch.
  int            wrAddrQ[$];
  logic [DW-1:0] wrDataQ[$];
  int            wrCycQ[$];
  int            rdAddrQ[$];
  int            rdTotal = 0;
  int            accTotal = 0;
  int            viol = 0;

  always @(negedge Clk) begin
    if (Rst && en2 && we2) begin
      wrAddrQ.push_back(int'(Addr2));
      wrDataQ.push_back(Data_I);
      wrCycQ.push_back(cyc);
    end
    if (Rst && en2 && !we2) begin
      rdAddrQ.push_back(int'(Addr2));
      rdTotal++;
    end
    if (rdTotal - accTotal > 2) viol++;
    if (out_valid && out_ready) accTotal++;
    if (!Rst) accTotal = rdTotal;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_addr2"}, Addr2, 0);
    checkOutput({tag, "_data_i"}, Data_I, 0);
    checkOutput({tag, "_en2"}, en2, 0);
    checkOutput({tag, "_we2"}, we2, 0);
    checkOutput({tag, "_core_rst"}, core_rst, 1);
    checkOutput({tag, "_in_ready"}, in_ready, 0);
    checkOutput({tag, "_out_valid"}, out_valid, 0);
    checkOutput({tag, "_out_data"}, out_data, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_finished"}, finished, 0);
`ifdef GPP_HOST_LOADER_CHECKSUM_EN
    checkOutput({tag, "_load_sum"}, load_sum, 0);
    checkOutput({tag, "_dump_sum"}, dump_sum, 0);
`endif
  endtask

  // readyMode: 0 always ready, 1 pattern 1,0,0,1, 2 random, 3 never ready.
  task automatic applyStimulus(input int loadLen, input int dumpBase, input int dumpLen,
                               input int doneDelay, input int readyMode, input bit validConst,
                               input bit pokeStart, input bit abortDump);
    logic [DW-1:0] expQ[$];
    logic [DW-1:0] expLoadSum, expDumpSum;
    int wr0, rd0, viol0, idx, budget, lowCnt, nWr, nRd, gotN, finCnt, postFin, p, lim;
    expLoadSum = '0;
    expDumpSum = '0;
    for (int i = 0; i < loadLen; i++) begin
      refData[i]  = loadWords[i];
      refValid[i] = 1'b1;
      expLoadSum += loadWords[i];
    end
    for (int i = 0; i < dumpLen; i++) begin
      expQ.push_back(refRead((dumpBase + i) % DEPTH));
      expDumpSum += expQ[i];
    end
    wr0 = wrAddrQ.size();
    rd0 = rdAddrQ.size();
    viol0 = viol;

    @(posedge Clk); #1;
    start = 1'b1;
    load_len = (AW+1)'(loadLen);
    dump_base = AW'(dumpBase);
    dump_len = (AW+1)'(dumpLen);
    @(posedge Clk); #1;
    start = 1'b0;
    load_len = (AW+1)'($urandom);
    dump_base = AW'($urandom);
    dump_len = (AW+1)'($urandom);
    checkOutput("busy_after_start", busy, 1);

    idx = 0;
    budget = 0;
    while (idx < loadLen && budget < 2000) begin
      in_valid = validConst ? 1'b1 : ($urandom_range(0, 3) != 0);
      in_data = loadWords[idx];
      @(negedge Clk);
      if (in_valid && in_ready) idx++;
      @(posedge Clk); #1;
      budget++;
    end
    in_valid = 1'b0;
    in_data = DW'($urandom);
    if (budget >= 2000) checkOutput("load_timeout", idx, loadLen);

    @(negedge Clk);
    budget = 0;
    while (core_rst !== 1'b0 && budget < 200) begin
      @(negedge Clk);
      budget++;
    end
    if (budget >= 200) begin
      checkOutput("run_entry_timeout", core_rst, 0);
      return;
    end
    checkOutput("in_ready_after_load", in_ready, 0);
    nWr = wrAddrQ.size() - wr0;
    checkOutput("write_count", nWr, loadLen);
    lim = (nWr < loadLen) ? nWr : loadLen;
    for (int i = 0; i < lim; i++) begin
      checkOutput($sformatf("write_addr_%0d", i), wrAddrQ[wr0 + i], i);
      checkOutput($sformatf("write_data_%0d", i), wrDataQ[wr0 + i], loadWords[i]);
    end
    if (nWr > 0) begin
      checkOutput("core_rst_fall_after_last_write", cyc - wrCycQ[wr0 + nWr - 1], 1);
      if (validConst) checkOutput("write_back_to_back", wrCycQ[wr0 + nWr - 1] - wrCycQ[wr0], nWr - 1);
    end

    if (doneDelay == 0) Done = 1'b1;
    lowCnt = 1;
    for (int k = 1; k < 200; k++) begin
      @(posedge Clk); #1;
      if (k == doneDelay) Done = 1'b1;
      start = pokeStart && (k == 1);
      @(negedge Clk);
      if (core_rst) break;
      lowCnt++;
    end
    start = 1'b0;
    Done = 1'b0;
    checkOutput("run_cycles", lowCnt, ((doneDelay > 1) ? doneDelay : 1) + 1);
    if (dumpLen == 0) checkOutput("fin_after_done", finished, 1);

    gotN = 0;
    finCnt = finished ? 1 : 0;
    postFin = finCnt;
    p = 0;
    budget = 0;
    while (postFin < 3 && budget < 3000) begin
      @(posedge Clk); #1;
      case (readyMode)
        0: out_ready = 1'b1;
        1: out_ready = (p % 4 == 0) || (p % 4 == 3);
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
      p++;
      @(negedge Clk);
      if (abortDump && out_valid) begin
        Rst = 1'b0;
        #1;
        checkResetValues("abort");
        @(posedge Clk); #1;
        Rst = 1'b1;
        out_ready = 1'b0;
        return;
      end
      if (out_valid && out_ready) begin
        if (gotN < dumpLen) checkOutput($sformatf("dump_word_%0d", gotN), out_data, expQ[gotN]);
        else checkOutput("dump_extra_word", gotN + 1, dumpLen);
        gotN++;
      end
      if (finished) finCnt++;
      if (finCnt > 0) postFin++;
      budget++;
    end
    out_ready = 1'b0;
    if (budget >= 3000) checkOutput("dump_timeout_finished", finCnt, 1);
    checkOutput("finished_pulses", finCnt, 1);
    checkOutput("busy_after_fin", busy, 0);
    checkOutput("core_rst_after_fin", core_rst, 1);
    checkOutput("dump_word_count", gotN, dumpLen);
    nRd = rdAddrQ.size() - rd0;
    checkOutput("read_count", nRd, dumpLen);
    lim = (nRd < dumpLen) ? nRd : dumpLen;
    for (int i = 0; i < lim; i++)
      checkOutput($sformatf("read_addr_%0d", i), rdAddrQ[rd0 + i], (dumpBase + i) % DEPTH);
    checkOutput("outstanding_le_2", viol - viol0, 0);
`ifdef GPP_HOST_LOADER_CHECKSUM_EN
    checkOutput("load_sum", load_sum, expLoadSum);
    checkOutput("dump_sum", dump_sum, expDumpSum);
`endif
  endtask

  task automatic setCaseOneWords();
    loadWords = {16'h0011, 16'h0022, 16'h0033, 16'h0044};
  endtask

  task automatic setRandomWords(input int n);
    loadWords.delete();
    for (int i = 0; i < n; i++) loadWords.push_back(DW'($urandom));
  endtask

  initial begin
    Rst = 1'b0;
    start = 1'b0;
    load_len = '0;
    dump_base = '0;
    dump_len = '0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    Done = 1'b0;
    #12;
    checkResetValues("reset");
    @(posedge Clk); #1;
    Rst = 1'b1;

    setCaseOneWords();
    applyStimulus(4, 'h100, 3, 10, 0, 1'b1, 1'b0, 1'b0);
    setRandomWords(8);
    applyStimulus(8, 0, 8, 0, 1, 1'b0, 1'b0, 1'b0);
    loadWords.delete();
    applyStimulus(0, 'h3A, 0, 3, 0, 1'b1, 1'b0, 1'b0);
    setRandomWords(5);
    applyStimulus(5, DEPTH - 2, 4, 2, 2, 1'b0, 1'b1, 1'b0);
    setRandomWords(3);
    applyStimulus(3, 'h50, 6, 1, 3, 1'b1, 1'b0, 1'b1);
    setCaseOneWords();
    applyStimulus(4, 0, 4, 4, 2, 1'b1, 1'b0, 1'b0);
`ifdef GPP_HOST_LOADER_CHECKSUM_EN
    checkOutput("case1_load_sum", load_sum, 'hAA);
`endif
    for (int j = 0; j < 3; j++) begin
      int n;
      n = $urandom_range(1, 12);
      setRandomWords(n);
      applyStimulus(n, $urandom_range(0, DEPTH - 1), $urandom_range(1, 10),
                    $urandom_range(0, 5), 2, 1'b0, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/gpp_host_loader.md
Name: gpp_host_loader

Overview:
Host-side controller for port B of the dual-port SRAM in the GPP top level. It streams a program/data image into SRAM, then releases the GPP core from reset and waits for Done. It then freezes the core and streams a result window back out with valid/ready backpressure. It sits directly upstream of GPP_TOP's Addr2/Data_I/en2/we2 interface and downstream of its Data2_O/Done outputs.

Parameters:
ADDR_W, `SA_WIDTH (define.h), SRAM word-address width
DATA_W, `D_WIDTH (define.h), SRAM data width

Ports:
Clk  in  1  system clock; single clock domain
Rst  in  1  asynchronous reset, active-low
start  in  1  one-cycle request; sampled only in IDLE
load_len  in  ADDR_W+1  words to load, starting at address 0; range 0..2^ADDR_W
dump_base  in  ADDR_W  first address of the result window
dump_len  in  ADDR_W+1  words to dump; range 0..2^ADDR_W
in_valid / in_ready / in_data  in / out / in  1 / 1 / DATA_W  load stream
out_valid / out_ready / out_data  out / in / out  1 / 1 / DATA_W  dump stream
Addr2  out  ADDR_W  SRAM port B address
Data_I  out  DATA_W  SRAM write data
en2 / we2  out  1 / 1  SRAM port B enable / write enable
Data2_O  in  DATA_W  SRAM port B read data; 1-cycle read latency
Done  in  1  GPP completion flag
core_rst  out  1  drives GPP Rst, active-high; high holds the core in reset
busy  out  1  high in every state except IDLE
finished  out  1  one-cycle pulse at the end of the dump

Behaviour:
- Reset values: state=IDLE, Addr2=0, Data_I=0, en2=0, we2=0, core_rst=1, in_ready=0, out_valid=0, out_data=0, busy=0, finished=0, skid buffer empty.
- All outputs are registered.
- FSM states: IDLE, LOAD, RUN, DUMP, FIN.
- IDLE:
  - On start, latch load_len, dump_base and dump_len; clear the word counter.
  - Go to LOAD if load_len != 0, otherwise go to RUN.
  - start is ignored in every other state.
- LOAD:
  - in_ready=1.
  - Each handshake (in_valid & in_ready) produces, on the next cycle, en2=1, we2=1, Addr2=cnt, Data_I=in_data; then cnt++. Non-handshake cycles give en2=we2=0.
  - After the load_len-th handshake, in_ready drops the next cycle and the FSM goes to RUN.
  - Throughput is 1 word/cycle.
- RUN:
  - core_rst=0 from the first RUN cycle; en2=0.
  - Done is ignored during the first RUN cycle (stale from reset).
  - Done=1 on any later cycle sets core_rst=1 on the next cycle and moves to DUMP.
  - No timeout.
- DUMP:
  - Issue a read (en2=1, we2=0, Addr2=(dump_base+rd_cnt) mod 2^ADDR_W) only when skid occupancy + reads in flight < 2.
  - Read data is captured into the skid buffer one cycle after issue.
  - out_valid is high whenever the skid is non-empty. A word leaves on out_valid & out_ready; order is preserved and no word is dropped or duplicated.
  - After dump_len words have been accepted, go to FIN. dump_len==0 goes straight to FIN.
  - Address wrap past 2^ADDR_W-1 is to 0.
- FIN: finished=1 for exactly one cycle, then IDLE. core_rst stays 1.
- Async reset mid-operation aborts immediately to the reset values. The partially written SRAM image is not cleared.
- core_rst=1 during LOAD and DUMP guarantees port A is idle while port B is in use. Simultaneous writes to the same address therefore cannot occur.

Optional Feature:
GPP_HOST_LOADER_CHECKSUM_EN
- Defined:
  - Adds outputs load_sum and dump_sum (DATA_W each).
  - load_sum is the modulo-2^DATA_W sum of all accepted in_data words; dump_sum is the sum of all accepted out_data words.
  - Both clear on start and in reset, and hold their values after FIN.
- Undefined: the ports and the adders do not exist. All other behaviour is identical.

Decomposition:
- Shared package/header (define.h): ADDR_W/DATA_W defaults via `SA_WIDTH/`D_WIDTH, and the 3-bit FSM state encodings HL_IDLE=0, HL_LOAD=1, HL_RUN=2, HL_DUMP=3, HL_FIN=4.
- One sub-module, hl_skid_buf: 2-entry FIFO with push/pop/count and pass-through ordering, used in DUMP.

Test Plan:
1. Reset, then start with load_len=4 and data 0x11,0x22,0x33,0x44 (in_valid constant) -> writes at addresses 0..3 on 4 consecutive cycles, in_ready low afterwards, core_rst falls the cycle after the last write.
2. Done asserted 10 cycles into RUN with dump_base=0x100, dump_len=3, out_ready=1 -> core_rst=1 next cycle, out_data equals SRAM[0x100..0x102] in order, then one finished pulse and busy=0.
3. Dump with out_ready toggling 1,0,0,1,... and dump_len=8 -> all 8 words delivered exactly once in order, never more than 2 reads outstanding plus buffered.
4. load_len=0 and dump_len=0 -> LOAD and DUMP skipped, finished pulses 1 cycle after Done is accepted, no en2 activity.
5. dump_base=2^ADDR_W-2, dump_len=4 -> read addresses 2^ADDR_W-2, 2^ADDR_W-1, 0, 1.
6. Rst low during DUMP with out_valid=1 -> all outputs return to reset values that cycle. A new start then completes normally; with GPP_HOST_LOADER_CHECKSUM_EN defined, load_sum=0xAA for the case-1 data.
